// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM. Strobes are registered from the next state;
// the only combinational path is the branch PCWrite term on Zero in BRANCH.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtZero,
  output logic [1:0] PCSource,
  output logic [3:0] ALUOperation
);

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_NOR = 4'b0010,
                         ALU_ADD = 4'b0011, ALU_SUB = 4'b0100, ALU_SLL = 4'b0101,
                         ALU_SRL = 4'b0110, ALU_LUI = 4'b0111;

  localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04,
                         OP_BNE  = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C,
                         OP_ORI  = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                         OP_SW   = 6'h2B;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXE, S_RTWB, S_BRANCH, S_IMMEXE, S_IMMWB, S_JUMP
  } state_t;

  typedef struct packed {
    logic       pcw;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       regdst;
    logic       m2r;
    logic       regw;
    logic       srca;
    logic [1:0] srcb;
    logic       extz;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   bne_q;

  function automatic logic [3:0] rt_op(input logic [5:0] f);
    case (f)
      6'h20:   return ALU_ADD;
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h27:   return ALU_NOR;
      6'h00:   return ALU_SLL;
      6'h02:   return ALU_SRL;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic rt_legal(input logic [5:0] f);
    case (f)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] imm_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_R:                             state_d = S_RTEXE;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IMMEXE;
          OP_J:                             state_d = S_JUMP;
          default:                          state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_RTEXE:  state_d = S_RTWB;
      S_IMMEXE: state_d = S_IMMWB;
      S_MEMWB, S_MEMWR, S_RTWB, S_BRANCH, S_IMMWB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_INIT;
    endcase
  end

  // Strobes for the state being entered; Opcode/Funct are stable from DECODE on.
  always_comb begin
    ctrl_d       = '0;
    ctrl_d.aluop = ALU_ADD;
    case (state_d)
      S_INIT:   ctrl_d.aluop = ALU_AND;
      S_FETCH:  begin ctrl_d.pcw = 1'b1; ctrl_d.mrd = 1'b1; ctrl_d.irw = 1'b1; ctrl_d.srcb = 2'b01; end
      S_DECODE: ctrl_d.srcb = 2'b11;
      S_MEMADR: begin ctrl_d.srca = 1'b1; ctrl_d.srcb = 2'b10; end
      S_MEMRD:  begin ctrl_d.mrd = 1'b1; ctrl_d.iord = 1'b1; end
      S_MEMWB:  begin ctrl_d.regw = 1'b1; ctrl_d.m2r = 1'b1; end
      S_MEMWR:  begin ctrl_d.mwr = 1'b1; ctrl_d.iord = 1'b1; end
      S_RTEXE:  begin ctrl_d.srca = 1'b1; ctrl_d.aluop = rt_op(Funct); end
      S_RTWB:   begin ctrl_d.regdst = 1'b1; ctrl_d.regw = rt_legal(Funct); end
      S_BRANCH: begin ctrl_d.srca = 1'b1; ctrl_d.aluop = ALU_SUB; ctrl_d.pcsrc = 2'b01; end
      S_IMMEXE: begin
        ctrl_d.srca  = 1'b1;
        ctrl_d.srcb  = 2'b10;
        ctrl_d.aluop = imm_op(Opcode);
        ctrl_d.extz  = (Opcode != OP_ADDI);
      end
      S_IMMWB:  begin
        ctrl_d.regw  = 1'b1;
        ctrl_d.aluop = imm_op(Opcode);
        ctrl_d.extz  = (Opcode != OP_ADDI);
      end
      S_JUMP:   begin ctrl_d.pcw = 1'b1; ctrl_d.pcsrc = 2'b10; end
      default:  ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      ctrl_q  <= '0;
      bne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      if (state_q == S_DECODE) bne_q <= (Opcode == OP_BNE);
    end
  end

  assign PCWrite      = ctrl_q.pcw | ((state_q == S_BRANCH) & (Zero ^ bne_q));
  assign IorD         = ctrl_q.iord;
  assign MemRead      = ctrl_q.mrd;
  assign MemWrite     = ctrl_q.mwr;
  assign IRWrite      = ctrl_q.irw;
  assign RegDst       = ctrl_q.regdst;
  assign MemtoReg     = ctrl_q.m2r;
  assign RegWrite     = ctrl_q.regw;
  assign ALUSrcA      = ctrl_q.srca;
  assign ALUSrcB      = ctrl_q.srcb;
  assign ExtZero      = ctrl_q.extz;
  assign PCSource     = ctrl_q.pcsrc;
  assign ALUOperation = ctrl_q.aluop;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction cycle-by-cycle expected
// strobes from an instruction-class model, directed cases then random ones.
module tb_mips_multicycle_control;
  logic       clk = 1'b0, reset = 1'b0, Zero = 1'b0;
  logic [5:0] Opcode = 6'h00, Funct = 6'h00;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ExtZero;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOperation;
  int checks = 0, errors = 0;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtZero(ExtZero), .PCSource(PCSource),
    .ALUOperation(ALUOperation)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // {PCWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ExtZero,PCSource,ALUOperation}
  function automatic logic [17:0] pk(input logic pcw, iord, mrd, mwr, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, input logic ez,
                                     input logic [1:0] ps, input logic [3:0] op);
    return {pcw, iord, mrd, mwr, irw, rd, m2r, rw, sa, sb, ez, ps, op};
  endfunction

  function automatic int ilen(input logic [5:0] o);
    case (o)
      6'h23: return 5;
      6'h2B, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0F: return 4;
      6'h04, 6'h05, 6'h02: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int fn_code(input logic [5:0] f); // -1 = illegal
    case (f)
      6'h20: return 3; 6'h22: return 4; 6'h24: return 0; 6'h25: return 1;
      6'h27: return 2; 6'h00: return 5; 6'h02: return 6;
      default: return -1;
    endcase
  endfunction

  function automatic logic [17:0] expect_at(input logic [5:0] o, f, input int k, input logic z);
    int fc;
    logic [3:0] iop;
    logic ez;
    if (k == 0) return pk(1,0,1,0,1,0,0,0,0, 2'd1, 0, 2'd0, 4'd3);
    if (k == 1) return pk(0,0,0,0,0,0,0,0,0, 2'd3, 0, 2'd0, 4'd3);
    fc = fn_code(f);
    iop = (o == 6'h0C) ? 4'd0 : (o == 6'h0D) ? 4'd1 : (o == 6'h0F) ? 4'd7 : 4'd3;
    ez = (o != 6'h08);
    case (o)
      6'h23, 6'h2B: begin
        if (k == 2) return pk(0,0,0,0,0,0,0,0,1, 2'd2, 0, 2'd0, 4'd3);
        if (o == 6'h2B) return pk(0,1,0,1,0,0,0,0,0, 2'd0, 0, 2'd0, 4'd3);
        if (k == 3) return pk(0,1,1,0,0,0,0,0,0, 2'd0, 0, 2'd0, 4'd3);
        return pk(0,0,0,0,0,0,1,1,0, 2'd0, 0, 2'd0, 4'd3);
      end
      6'h00: begin
        if (k == 2) return pk(0,0,0,0,0,0,0,0,1, 2'd0, 0, 2'd0, (fc < 0) ? 4'd0 : 4'(fc));
        return pk(0,0,0,0,0,1,0,(fc >= 0),0, 2'd0, 0, 2'd0, 4'd3);
      end
      6'h04: return pk(z,0,0,0,0,0,0,0,1, 2'd0, 0, 2'd1, 4'd4);
      6'h05: return pk(!z,0,0,0,0,0,0,0,1, 2'd0, 0, 2'd1, 4'd4);
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        if (k == 2) return pk(0,0,0,0,0,0,0,0,1, 2'd2, ez, 2'd0, iop);
        return pk(0,0,0,0,0,0,0,1,0, 2'd0, ez, 2'd0, iop);
      end
      default: return pk(1,0,0,0,0,0,0,0,0, 2'd0, 0, 2'd2, 4'd3); // j
    endcase
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    logic [17:0] obs;
    obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ExtZero, PCSource, ALUOperation};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%05h exp=%05h", tag, obs, exp);
    end
  endtask

  // Entered just before the edge that moves the FSM into FETCH.
  task automatic run_instr(input logic [5:0] o, f, input int ncyc);
    int n;
    n = (ilen(o) < ncyc) ? ilen(o) : ncyc;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin Opcode = o; Funct = f; end
      Zero = 1'($urandom);
      @(negedge clk);
      check($sformatf("op%02h fn%02h k%0d", o, f, k), expect_at(o, f, k, Zero));
      if (k == 2 && (o == 6'h04 || o == 6'h05)) begin
        Zero = ~Zero; #1;
        check($sformatf("op%02h zero_toggle", o), expect_at(o, f, k, Zero));
      end
    end
  endtask

  logic [5:0] ops [10] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h02};
  logic [5:0] fns [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02};

  initial begin
    logic [5:0] o, f;
    repeat (2) @(negedge clk);
    check("reset_hold", '0);
    reset = 1'b1;
    check("init", '0);
    run_instr(6'h23, 6'h00, 99);
    run_instr(6'h2B, 6'h00, 99);
    run_instr(6'h00, 6'h22, 99);
    run_instr(6'h00, 6'h3F, 99);
    run_instr(6'h04, 6'h00, 99);
    run_instr(6'h05, 6'h00, 99);
    run_instr(6'h0D, 6'h00, 99);
    run_instr(6'h0F, 6'h00, 99);
    run_instr(6'h08, 6'h00, 99);
    run_instr(6'h3F, 6'h00, 99);
    run_instr(6'h02, 6'h00, 99);
    // Abandon a sw while MemWrite is high.
    run_instr(6'h2B, 6'h00, 4);
    #2 reset = 1'b0;
    #1 check("reset_async_memwr", '0);
    @(posedge clk); #1;
    check("reset_held_edge", '0);
    @(negedge clk);
    reset = 1'b1;
    check("init_after_reset", '0);
    run_instr(6'h00, 6'h20, 99);
    for (int i = 0; i < 80; i++) begin
      o = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 6)];
      run_instr(o, f, 99);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle MIPS control unit: a Moore FSM, plus one Mealy branch-enable term, that sequences datapath strobes across fetch, decode, execute, memory and writeback. It is the producing end of the 4-bit ALU operation interface and drives the ALU's `ALUOperation` input every cycle. It decodes `Opcode`/`Funct` from the instruction register and consumes the ALU `Zero` flag for branches.

## Interface
Parameters: none. ALU codes are fixed local constants: AND=0000, OR=0001, NOR=0010, ADD=0011, SUB=0100, SLL=0101, SRL=0110, LUI=0111.
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- Opcode  in  6  IR[31:26], stable from DECODE until the next FETCH
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC load enable
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read
- MemWrite  out  1  memory write
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register: 0=rt, 1=rd
- MemtoReg  out  1  write data: 0=ALUOut, 1=MDR
- RegWrite  out  1  register file write
- ALUSrcA  out  1  A operand: 0=PC, 1=rs
- ALUSrcB  out  2  B operand: 00=rt, 01=4, 10=ext imm, 11=ext imm<<2
- ExtZero  out  1  immediate extension: 1=zero-extend, 0=sign-extend
- PCSource  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- ALUOperation  out  4  ALU operation code

## Operation
States: INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, BRANCH, IMMEXE, IMMWB, JUMP.

Outputs not listed for a state are 0. ALUOperation defaults to ADD in states that don't list it.
- INIT: all outputs 0, including ALUOperation=0000. Always goes to FETCH.
- FETCH: MemRead, IRWrite, PCWrite; ALUSrcB=01; ADD. Goes to DECODE.
- DECODE: ALUSrcB=11; ADD, which precomputes the branch target into ALUOut.
  - lw (0x23) and sw (0x2B) go to MEMADR.
  - R-type (0x00) goes to RTEXE.
  - beq (0x04) and bne (0x05) go to BRANCH.
  - addi (0x08), andi (0x0C), ori (0x0D) and lui (0x0F) go to IMMEXE.
  - j (0x02) goes to JUMP.
  - Any other opcode goes to FETCH as a no-op, with no write strobes.
- MEMADR: ALUSrcA=1, ALUSrcB=10; ADD. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: MemRead, IorD. Goes to MEMWB.
- MEMWB: RegWrite, MemtoReg. Goes to FETCH.
- MEMWR: MemWrite, IorD. Goes to FETCH.
- RTEXE: ALUSrcA=1, ALUSrcB=00. ALUOperation by Funct:
  - 0x20 add → ADD; 0x22 sub → SUB; 0x24 and → AND
  - 0x25 or → OR; 0x27 nor → NOR; 0x00 sll → SLL; 0x02 srl → SRL
  - Any other Funct → AND.
  - Goes to RTWB.
- RTWB: RegDst=1. RegWrite only if Funct was legal; an illegal Funct completes as a no-op. Goes to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00; SUB; PCSource=01.
  - PCWrite = Zero for beq, ~Zero for bne. This is combinational on Zero in this state only.
  - Goes to FETCH.
- IMMEXE: ALUSrcA=1, ALUSrcB=10.
  - addi → ADD, ExtZero=0.
  - andi → AND, ori → OR, lui → LUI, each with ExtZero=1.
  - Goes to IMMWB.
- IMMWB: RegWrite, RegDst=0, MemtoReg=0. Holds ExtZero and ALUOperation from IMMEXE. Goes to FETCH.
- JUMP: PCWrite, PCSource=10. Goes to FETCH.

## Timing
- State register: asynchronous clear to INIT on reset low. All other transitions occur on the rising clk edge.
- Reset value of every output is 0, with ALUOperation=0000.
- First FETCH is the cycle after the first rising edge with reset high.
- Cycles per instruction, FETCH through last state: lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3, illegal opcode 2.
- Exactly one FETCH per instruction. IRWrite is high only in FETCH.
- MemWrite and RegWrite are never asserted in the same cycle.
- Reset mid-instruction: outputs go to 0 immediately, with no clock needed, and the partial instruction is abandoned.
- Opcode/Funct changes outside DECODE..end of instruction are ignored.

## Test plan
- Reset low mid-MEMWR (MemWrite=1) → MemWrite drops same cycle. On release, INIT then FETCH with MemRead=1, IRWrite=1, PCWrite=1, ALUOperation=0011.
- lw (0x23) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. MemRead, IorD=1 in cycle 4. RegWrite=1, MemtoReg=1 in cycle 5. Next FETCH in cycle 6.
- R-type sub (Funct 0x22) → ALUOperation=0100 in RTEXE; RegWrite=1, RegDst=1 in RTWB. Funct 0x3F → ALUOperation=0000 and RegWrite stays 0.
- beq with Zero=1 → PCWrite=1, PCSource=01 in cycle 3. bne with Zero=1 → PCWrite=0. Toggle Zero within BRANCH → PCWrite follows combinationally.
- ori (0x0D) → ALUOperation=0001, ExtZero=1, ALUSrcB=10 in IMMEXE. lui (0x0F) → ALUOperation=0111. addi → 0011 with ExtZero=0.
- Opcode 0x3F → FETCH, DECODE, FETCH with no PCWrite, RegWrite or MemWrite in DECODE. j (0x02) → PCWrite=1, PCSource=10 in cycle 3.
